// File: rtl/alu_pkg.sv
// Shared decode definitions for the ALU operand/issue stage:
// opcode and funct3 constants plus the RV32I R/I-type field layout.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 codes whose immediate form carries a shift amount instead of imm[11:0]
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SR  = 3'd5;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    function automatic logic is_shift_imm(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SR);
    endfunction

endpackage

// File: rtl/alu_register_file.sv
// 32 x DATA_WIDTH register file: two combinational read ports, one write port.
// x0 is never written and always reads as zero; the whole array clears on reset.
module alu_register_file #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            rd_addr_a,
    input  logic [4:0]            rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [32];

    // Storage: clear on reset, drop writes to x0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads return only completed writes
    always_comb begin
        rd_data_a = (rd_addr_a == 5'd0) ? '0 : mem[rd_addr_a];
        rd_data_b = (rd_addr_b == 5'd0) ? '0 : mem[rd_addr_b];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the arithmetic unit: decodes OP / OP-IMM words, reads
// operands, tracks pending destinations in a busy scoreboard and stalls on
// RAW/WAW hazards. One output register holds the issued op until consumed.
// Optional feature: define ALU_OPERAND_BYPASS_EN to forward a same-cycle
// writeback into the source operands instead of stalling.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  wb_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] lhs,
    output logic [DATA_WIDTH-1:0] rhs,
    output logic [2:0]            operation,
    output logic [6:0]            metadata,
    output logic                  lhs_valid,
    output logic                  rhs_valid,
    output logic                  operation_valid,
    output logic                  metadata_valid,
    output logic [4:0]            rd,
    input  logic                  issue_ready,
    output logic                  illegal
);

    instr_t                f;
    logic                  is_op, is_op_imm, legal;
    logic                  byp_a, byp_b, hazard, accept, issue;
    logic [DATA_WIDTH-1:0] rf_a, rf_b, src_a, src_b;
    logic [DATA_WIDTH-1:0] rhs_next;
    logic [6:0]            md_next;
    logic [31:0]           busy, busy_next;
    logic                  out_valid;

    assign f         = instr_t'(instr);
    assign is_op     = (f.opcode == OPC_OP);
    assign is_op_imm = (f.opcode == OPC_OP_IMM);
    assign legal     = is_op || is_op_imm;

    alu_register_file #(.DATA_WIDTH(DATA_WIDTH)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (f.rs1),
        .rd_addr_b (f.rs2),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

`ifdef ALU_OPERAND_BYPASS_EN
    assign byp_a = wb_en && (wb_addr == f.rs1) && (f.rs1 != 5'd0);
    assign byp_b = wb_en && (wb_addr == f.rs2) && (f.rs2 != 5'd0);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign src_a = byp_a ? wb_data : rf_a;
    assign src_b = byp_b ? wb_data : rf_b;

    // Only legal words can stall; rs2 is a real source only for register-register ops
    assign hazard = legal && ((busy[f.rs1] && !byp_a) ||
                              (is_op && busy[f.rs2] && !byp_b) ||
                              busy[f.rd]);

    assign instr_ready = (!out_valid || issue_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;
    assign issue       = accept && legal;

    // Second operand and metadata selection per opcode / funct3
    always_comb begin
        rhs_next = src_b;
        md_next  = f.funct7;
        if (is_op_imm) begin
            if (is_shift_imm(f.funct3)) begin
                rhs_next = {{(DATA_WIDTH-5){1'b0}}, f.rs2};
            end else begin
                rhs_next = {{(DATA_WIDTH-12){f.funct7[6]}}, f.funct7, f.rs2};
                md_next  = 7'd0;
            end
        end
    end

    // Scoreboard update: writeback clears, issue sets, set wins on collision
    always_comb begin
        busy_next = busy;
        if (wb_en) busy_next[wb_addr] = 1'b0;
        if (issue && (f.rd != 5'd0)) busy_next[f.rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_next;
    end

    // Output register: load on issue, hold until consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            lhs       <= '0;
            rhs       <= '0;
            operation <= '0;
            metadata  <= '0;
            rd        <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            lhs       <= src_a;
            rhs       <= rhs_next;
            operation <= f.funct3;
            metadata  <= md_next;
            rd        <= f.rd;
        end else if (issue_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Unsupported opcode pulse, one cycle after the word is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal <= 1'b0;
        else      illegal <= accept && !legal;
    end

    assign lhs_valid       = out_valid;
    assign rhs_valid       = out_valid;
    assign operation_valid = out_valid;
    assign metadata_valid  = out_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios followed by
// randomized traffic, checked against an architectural register/busy model.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] instr = '0;
    logic        instr_valid = 0;
    logic        instr_ready;
    logic        wb_en = 0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] lhs, rhs;
    logic [2:0]  operation;
    logic [6:0]  metadata;
    logic        lhs_valid, rhs_valid, operation_valid, metadata_valid;
    logic [4:0]  rd;
    logic        issue_ready = 0;
    logic        illegal;

    alu_operand_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
        .lhs_valid(lhs_valid), .rhs_valid(rhs_valid), .operation_valid(operation_valid),
        .metadata_valid(metadata_valid), .rd(rd), .issue_ready(issue_ready), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [2:0]  op;
        logic [6:0]  md;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;

    // Architectural model state
    logic [31:0] m_r [32];
    bit          m_busy [32];
    bit          m_ov;
    bit          m_ill;

    localparam logic [31:0] ADD_X3 = 32'h002081B3;
    localparam logic [31:0] SUB_X6 = 32'h40118333;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_r[i] = '0; m_busy[i] = 0; end
        m_ov = 0; m_ill = 0;
        q.delete();
    endtask

    // One clock of stimulus; predicts the edge outcome and advances the model
    task automatic step(input bit iv, input logic [31:0] ins, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit ir, output bit acc);
        logic [6:0] opc; logic [4:0] rdi, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
        bit legal, is_op, b1, b2, haz, rdy;
        exp_t e;
        @(negedge clk);
        instr_valid = iv; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; issue_ready = ir;
        #1;
        opc = ins[6:0]; rdi = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        is_op = (opc == 7'h33);
        legal = is_op || (opc == 7'h13);
        b1 = BYP && we && (wa == rs1) && (rs1 != 0);
        b2 = BYP && we && (wa == rs2) && (rs2 != 0);
        haz = legal && ((m_busy[rs1] && !b1) || (is_op && m_busy[rs2] && !b2) || m_busy[rdi]);
        rdy = (!m_ov || ir) && !haz;
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
        acc = iv && rdy;
        if (acc && legal) begin
            e.lhs = b1 ? wd : m_r[rs1];
            e.op  = f3;
            e.rd  = rdi;
            if (is_op) begin
                e.rhs = b2 ? wd : m_r[rs2];
                e.md  = f7;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                e.rhs = {27'd0, rs2};
                e.md  = f7;
            end else begin
                e.rhs = 32'($signed(ins[31:20]));
                e.md  = 7'd0;
            end
            q.push_back(e);
        end
        m_ill = acc && !legal;
        m_ov  = (acc && legal) ? 1'b1 : (ir ? 1'b0 : m_ov);
        if (we && wa != 0) begin m_r[wa] = wd; m_busy[wa] = 0; end
        if (acc && legal && rdi != 0) m_busy[rdi] = 1;
    endtask

    // Monitor: pop on each newly presented op, verify held ops stay stable
    initial begin
        bit prev_ov = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                prev_ov = 0;
            end else begin
                chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
                chk("valids_agree", {28'd0, lhs_valid, rhs_valid, operation_valid, metadata_valid},
                    {28'd0, {4{lhs_valid}}});
                if (lhs_valid && (!prev_ov || issue_ready)) begin
                    if (q.size() == 0) begin
                        chk("unexpected_issue", 32'd1, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("lhs", lhs, cur.lhs);
                        chk("rhs", rhs, cur.rhs);
                        chk("operation", {29'd0, operation}, {29'd0, cur.op});
                        chk("metadata", {25'd0, metadata}, {25'd0, cur.md});
                        chk("rd", {27'd0, rd}, {27'd0, cur.rd});
                    end
                end else if (lhs_valid) begin
                    chk("held_lhs", lhs, cur.lhs);
                    chk("held_rhs", rhs, cur.rhs);
                    chk("held_rd", {27'd0, rd}, {27'd0, cur.rd});
                end
                prev_ov = lhs_valid;
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        if (k == 0) begin
            w[6:0] = (($urandom & 1) != 0) ? 7'h63 : 7'h03;
        end else if (k < 5) begin
            w[6:0] = 7'h33;
            w[31:25] = (($urandom & 1) != 0) ? 7'h20 : 7'h00;
        end else begin
            w[6:0] = 7'h13;
        end
        return w;
    endfunction

    initial begin
        bit acc;
        logic [31:0] cur_ins;
        logic [4:0] wa;
        int nb;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_lhs", lhs, 0);
        chk("rst_rhs", rhs, 0);
        chk("rst_valid", {31'd0, lhs_valid}, 0);
        chk("rst_rd", {27'd0, rd}, 0);
        chk("rst_illegal", {31'd0, illegal}, 0);
        rst = 1;

        // Basic add
        step(0, 0, 1, 5'd1, 32'd5, 1, acc);
        step(0, 0, 1, 5'd2, 32'd7, 1, acc);
        step(1, ADD_X3, 0, 0, 0, 1, acc);
        @(posedge clk); #1;
        chk("t1_lhs", lhs, 5); chk("t1_rhs", rhs, 7); chk("t1_rd", {27'd0, rd}, 3);
        chk("t1_op", {29'd0, operation}, 0); chk("t1_md", {25'd0, metadata}, 0);

        // Immediates: addi x4,x1,-1 then srai x5,x1,3
        step(1, 32'hFFF08213, 0, 0, 0, 1, acc);
        @(posedge clk); #1;
        chk("t2_addi_rhs", rhs, 32'hFFFFFFFF); chk("t2_addi_md", {25'd0, metadata}, 0);
        step(1, 32'h4030D293, 0, 0, 0, 1, acc);
        @(posedge clk); #1;
        chk("t2_srai_rhs", rhs, 3); chk("t2_srai_md", {25'd0, metadata}, 7'h20);
        chk("t2_srai_op", {29'd0, operation}, 5);

        // RAW hazard on x3 (busy since the add)
        step(1, SUB_X6, 0, 0, 0, 1, acc);
        chk("t3_stall0", {31'd0, instr_ready}, 0);
        step(1, SUB_X6, 0, 0, 0, 1, acc);
        chk("t3_stall1", {31'd0, instr_ready}, 0);
        step(1, SUB_X6, 1, 5'd3, 32'd100, 1, acc);
        chk("t3_wb_cycle_ready", {31'd0, instr_ready}, {31'd0, BYP});
        if (!acc) begin
            step(1, SUB_X6, 0, 0, 0, 1, acc);
            chk("t3_after_wb_ready", {31'd0, instr_ready}, 1);
        end
        @(posedge clk); #1;
        chk("t3_lhs", lhs, 100); chk("t3_rd", {27'd0, rd}, 6);

        // Back-pressure: three held cycles, then one op per cycle
        step(1, 32'h002083B3, 0, 0, 0, 1, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00208433, 0, 0, 0, 0, acc);
            chk("t4_held_ready", {31'd0, instr_ready}, 0);
        end
        step(1, 32'h00208433, 0, 0, 0, 1, acc);
        chk("t4_release_accept", {31'd0, acc}, 1);
        step(1, 32'h002084B3, 0, 0, 0, 1, acc);
        chk("t4_next_accept", {31'd0, acc}, 1);
        step(0, 0, 0, 0, 0, 1, acc);

        // Unsupported opcode
        step(1, 32'h00000063, 0, 0, 0, 1, acc);
        @(posedge clk); #1;
        chk("t5_illegal", {31'd0, illegal}, 1);
        chk("t5_no_issue", {31'd0, lhs_valid}, 0);
        step(0, 0, 0, 0, 0, 1, acc);
        @(posedge clk); #1;
        chk("t5_pulse_end", {31'd0, illegal}, 0);

        // Randomized traffic
        cur_ins = rand_instr();
        for (int c = 0; c < 600; c++) begin
            bit iv, we, ir;
            iv = ($urandom_range(0, 9) < 8);
            ir = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 1) == 1);
            wa = 5'($urandom_range(0, 31));
            nb = 0;
            for (int r = 1; r < 32; r++) if (m_busy[r]) nb++;
            if (nb > 0 && $urandom_range(0, 9) < 7) begin
                do wa = 5'($urandom_range(1, 31)); while (!m_busy[wa]);
            end
            step(iv, cur_ins, we, wa, $urandom, ir, acc);
            if (acc) cur_ins = rand_instr();
        end

        // Reset with an op in flight and x3 busy
        step(0, 0, 1, 5'd3, 32'd9, 1, acc);
        step(1, ADD_X3, 0, 0, 0, 0, acc);
        @(negedge clk);
        instr_valid = 0; wb_en = 0; rst = 0;
        model_reset();
        #1;
        chk("t6_lhs", lhs, 0); chk("t6_rhs", rhs, 0);
        chk("t6_valid", {31'd0, lhs_valid}, 0); chk("t6_rd", {27'd0, rd}, 0);
        @(negedge clk);
        rst = 1;
        step(1, ADD_X3, 0, 0, 0, 1, acc);
        chk("t6_accept_after_release", {31'd0, acc}, 1);
        @(posedge clk); #1;
        chk("t6_rd_after", {27'd0, rd}, 3); chk("t6_lhs_after", lhs, 0);

        // Drain
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
